// File: rtl/mbt_scan_ctrl.sv
// mbt_scan_ctrl: walks a H_PIX x V_PIX grid in (11,16) fixed point, runs the
// ALU once per pixel and writes the iteration count to wr_addr=row*H_PIX+col.
// Ports: clk, rst (sync, active-low); frame_start, x_min, y_max, step in;
// alu_valid/alu_iter from ALU, alu_clr/alu_start/c_real/c_img to ALU;
// wr_en/wr_addr/wr_data/wr_ready pixel sink; busy, frame_done status.
// Option MBT_WDT_EN: 255-cycle WAIT watchdog writing ITER_MAX, wdt_err out.
module mbt_scan_ctrl #(
  parameter int H_PIX    = 320,
  parameter int V_PIX    = 240,
  parameter int ADDR_W   = 17,
  parameter int ITER_MAX = 99
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [15:0]       x_min,
  input  logic [15:0]       y_max,
  input  logic [15:0]       step,
  input  logic              alu_valid,
  input  logic [6:0]        alu_iter,
  input  logic              wr_ready,
  output logic              alu_clr,
  output logic              alu_start,
  output logic [15:0]       c_real,
  output logic [15:0]       c_img,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [6:0]        wr_data,
  output logic              busy,
  output logic              frame_done
`ifdef MBT_WDT_EN
  ,
  output logic              wdt_err
`endif
);

  localparam int CW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int RW = (V_PIX > 1) ? $clog2(V_PIX) : 1;

  typedef enum logic [2:0] {
    IDLE, CLEAR, LAUNCH, WAIT, WRITE, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [15:0]       x_lat_q, x_lat_d;
  logic [15:0]       step_q, step_d;
  logic [15:0]       c_real_q, c_real_d;
  logic [15:0]       c_img_q, c_img_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [6:0]        wr_data_q, wr_data_d;
  logic              alu_clr_q, alu_clr_d;
  logic              alu_start_q, alu_start_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
`ifdef MBT_WDT_EN
  logic [7:0]        wdt_cnt_q, wdt_cnt_d;
  logic              wdt_err_q, wdt_err_d;
`endif

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    x_lat_d   = x_lat_q;
    step_d    = step_q;
    c_real_d  = c_real_q;
    c_img_d   = c_img_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef MBT_WDT_EN
    wdt_cnt_d = wdt_cnt_q;
    wdt_err_d = wdt_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          x_lat_d   = x_min;
          step_d    = step;
          col_d     = '0;
          row_d     = '0;
          c_real_d  = x_min;
          c_img_d   = y_max;
          wr_addr_d = '0;
`ifdef MBT_WDT_EN
          wdt_err_d = 1'b0;
`endif
          state_d   = CLEAR;
        end
      end
      CLEAR: state_d = LAUNCH;
      LAUNCH: begin
`ifdef MBT_WDT_EN
        wdt_cnt_d = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (alu_valid) begin
          wr_data_d = alu_iter;
          state_d   = WRITE;
        end
`ifdef MBT_WDT_EN
        // 255th WAIT cycle without a result: give up on this pixel
        else if (wdt_cnt_q == 8'd254) begin
          wr_data_d = 7'(ITER_MAX);
          wdt_err_d = 1'b1;
          state_d   = WRITE;
        end else begin
          wdt_cnt_d = wdt_cnt_q + 8'd1;
        end
`endif
      end
      WRITE: begin
        if (wr_ready) begin
          if (col_q != CW'(H_PIX - 1)) begin
            col_d     = col_q + 1'b1;
            c_real_d  = c_real_q + step_q;
            wr_addr_d = wr_addr_q + 1'b1;
            state_d   = CLEAR;
          end else if (row_q != RW'(V_PIX - 1)) begin
            col_d     = '0;
            row_d     = row_q + 1'b1;
            c_real_d  = x_lat_q;
            c_img_d   = c_img_q - step_q;
            wr_addr_d = wr_addr_q + 1'b1;
            state_d   = CLEAR;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // outputs registered from next state so they line up with the state
    alu_clr_d    = (state_d == CLEAR);
    alu_start_d  = (state_d == LAUNCH);
    wr_en_d      = (state_d == WRITE);
    frame_done_d = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      x_lat_q      <= '0;
      step_q       <= '0;
      c_real_q     <= '0;
      c_img_q      <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      alu_clr_q    <= 1'b1;
      alu_start_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef MBT_WDT_EN
      wdt_cnt_q    <= '0;
      wdt_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      x_lat_q      <= x_lat_d;
      step_q       <= step_d;
      c_real_q     <= c_real_d;
      c_img_q      <= c_img_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      alu_clr_q    <= alu_clr_d;
      alu_start_q  <= alu_start_d;
      wr_en_q      <= wr_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef MBT_WDT_EN
      wdt_cnt_q    <= wdt_cnt_d;
      wdt_err_q    <= wdt_err_d;
`endif
    end
  end

  assign alu_clr    = alu_clr_q;
  assign alu_start  = alu_start_q;
  assign c_real     = c_real_q;
  assign c_img      = c_img_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
`ifdef MBT_WDT_EN
  assign wdt_err    = wdt_err_q;
`endif

endmodule
